// File: rtl/digilock_ctrl.sv
// digilock_ctrl: digit-by-digit password lock controller.
// Handles password entry and checking, a bounded retry counter with a timed
// lockout, password change from the OPEN state, and clear/abort handling.
// led and ssd are registered versions of a decode of the current state.
// Optional feature: define DIGILOCK_AUTO_RELOCK_EN to add an idle timer that
// returns OPEN to IDLE after RELOCK_CYC cycles without a button pulse.
module digilock_ctrl #(
    parameter int DIGITS      = 4,
    parameter int DIGIT_W     = 4,
    parameter int MAX_TRIES   = 3,
    parameter int LOCKOUT_CYC = 1024,
`ifdef DIGILOCK_AUTO_RELOCK_EN
    parameter int RELOCK_CYC  = 4096,
`endif
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_PWD = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 enter,
    input  logic                 change,
    input  logic [DIGIT_W-1:0]   switch,
    output logic [5:0]           led,
    output logic [5*DIGITS-1:0]  ssd
);

    localparam int PW     = DIGITS * DIGIT_W;
    localparam int IDX_W  = $clog2(DIGITS);
    localparam int FAIL_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W  = $clog2(LOCKOUT_CYC);

    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [FAIL_W-1:0] FAIL_MAX = FAIL_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0]  TMR_LOAD = TMR_W'(LOCKOUT_CYC - 1);

    // Seven-segment glyph codes: 5'b0xxxx shows a hex digit.
    localparam logic [4:0] G_0     = 5'h00;
    localparam logic [4:0] G_5     = 5'h05;
    localparam logic [4:0] G_C     = 5'h0C;
    localparam logic [4:0] G_D     = 5'h0D;
    localparam logic [4:0] G_E     = 5'h0E;
    localparam logic [4:0] G_BLANK = 5'h10;
    localparam logic [4:0] G_L     = 5'h11;
    localparam logic [4:0] G_P     = 5'h13;
    localparam logic [4:0] G_N     = 5'h14;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ENTRY   = 3'd1,
        S_CHECK   = 3'd2,
        S_OPEN    = 3'd3,
        S_SET     = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    state_t            state,    state_nxt;
    logic [PW-1:0]     passwd,   passwd_nxt;
    logic [PW-1:0]     in_pwd,   in_pwd_nxt;
    logic [PW-1:0]     new_pwd,  new_pwd_nxt;
    logic [IDX_W-1:0]  idx,      idx_nxt;
    logic [FAIL_W-1:0] fail_cnt, fail_cnt_nxt;
    logic [TMR_W-1:0]  lock_tmr, lock_tmr_nxt;

    logic [5:0]          led_nxt;
    logic [5*DIGITS-1:0] ssd_nxt;
    logic [1:0]          fail_sat;

`ifdef DIGILOCK_AUTO_RELOCK_EN
    localparam int RL_W = $clog2(RELOCK_CYC);
    localparam logic [RL_W-1:0] RL_LOAD = RL_W'(RELOCK_CYC - 1);
    logic [RL_W-1:0] relock_tmr, relock_tmr_nxt;
`endif

    // Write digit d into word at position pos; position 0 is the most
    // significant digit.
    function automatic logic [PW-1:0] put_digit(input logic [PW-1:0]      word,
                                                input logic [IDX_W-1:0]   pos,
                                                input logic [DIGIT_W-1:0] d);
        logic [PW-1:0] w;
        w = word;
        for (int i = 0; i < DIGITS; i++) begin
            if (pos == IDX_W'(i)) begin
                w[(DIGITS-1-i)*DIGIT_W +: DIGIT_W] = d;
            end
        end
        return w;
    endfunction

    // Four-glyph message right-aligned, blanks on the left.
    function automatic logic [5*DIGITS-1:0] message(input logic [4:0] a,
                                                    input logic [4:0] b,
                                                    input logic [4:0] c,
                                                    input logic [4:0] d);
        logic [5*DIGITS-1:0] s;
        s = {DIGITS{G_BLANK}};
        s[19:0] = {a, b, c, d};
        return s;
    endfunction

    // Live switch glyph at position pos, every other position blank.
    function automatic logic [5*DIGITS-1:0] digit_view(input logic [IDX_W-1:0]   pos,
                                                       input logic [DIGIT_W-1:0] d);
        logic [5*DIGITS-1:0] s;
        s = {DIGITS{G_BLANK}};
        for (int i = 0; i < DIGITS; i++) begin
            if (pos == IDX_W'(i)) begin
                s[(DIGITS-1-i)*5 +: 5] = {1'b0, 4'(d)};
            end
        end
        return s;
    endfunction

    // State and datapath registers; reset drops any partial entry or set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            passwd   <= DEFAULT_PWD;
            in_pwd   <= '0;
            new_pwd  <= '0;
            idx      <= '0;
            fail_cnt <= '0;
            lock_tmr <= '0;
        end else begin
            state    <= state_nxt;
            passwd   <= passwd_nxt;
            in_pwd   <= in_pwd_nxt;
            new_pwd  <= new_pwd_nxt;
            idx      <= idx_nxt;
            fail_cnt <= fail_cnt_nxt;
            lock_tmr <= lock_tmr_nxt;
        end
    end

`ifdef DIGILOCK_AUTO_RELOCK_EN
    // Idle timer for automatic relock out of OPEN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            relock_tmr <= '0;
        end else begin
            relock_tmr <= relock_tmr_nxt;
        end
    end
`endif

    // Next-state and datapath update; clr wins over enter, change wins over enter.
    always_comb begin
        state_nxt    = state;
        passwd_nxt   = passwd;
        in_pwd_nxt   = in_pwd;
        new_pwd_nxt  = new_pwd;
        idx_nxt      = idx;
        fail_cnt_nxt = fail_cnt;
        lock_tmr_nxt = lock_tmr;
`ifdef DIGILOCK_AUTO_RELOCK_EN
        relock_tmr_nxt = relock_tmr;
`endif
        case (state)
            S_IDLE: begin
                if (enter) begin
                    state_nxt  = S_ENTRY;
                    idx_nxt    = '0;
                    in_pwd_nxt = '0;
                end
            end
            S_ENTRY: begin
                if (clr) begin
                    idx_nxt    = '0;
                    in_pwd_nxt = '0;
                end else if (enter) begin
                    in_pwd_nxt = put_digit(in_pwd, idx, switch);
                    if (idx == IDX_LAST) begin
                        state_nxt = S_CHECK;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_CHECK: begin
                if (in_pwd == passwd) begin
                    state_nxt    = S_OPEN;
                    fail_cnt_nxt = '0;
`ifdef DIGILOCK_AUTO_RELOCK_EN
                    relock_tmr_nxt = RL_LOAD;
`endif
                end else if (fail_cnt + FAIL_W'(1) == FAIL_MAX) begin
                    state_nxt    = S_LOCKOUT;
                    fail_cnt_nxt = FAIL_MAX;
                    lock_tmr_nxt = TMR_LOAD;
                end else begin
                    state_nxt    = S_IDLE;
                    fail_cnt_nxt = fail_cnt + FAIL_W'(1);
                end
            end
            S_OPEN: begin
                if (change) begin
                    state_nxt   = S_SET;
                    idx_nxt     = '0;
                    new_pwd_nxt = '0;
                end else if (enter) begin
                    state_nxt = S_IDLE;
                end
`ifdef DIGILOCK_AUTO_RELOCK_EN
                else if (clr) begin
                    relock_tmr_nxt = RL_LOAD;
                end else if (relock_tmr == '0) begin
                    state_nxt = S_IDLE;
                end else begin
                    relock_tmr_nxt = relock_tmr - RL_W'(1);
                end
`endif
            end
            S_SET: begin
                if (clr) begin
                    state_nxt = S_OPEN;
`ifdef DIGILOCK_AUTO_RELOCK_EN
                    relock_tmr_nxt = RL_LOAD;
`endif
                end else if (enter) begin
                    new_pwd_nxt = put_digit(new_pwd, idx, switch);
                    if (idx == IDX_LAST) begin
                        passwd_nxt = put_digit(new_pwd, idx, switch);
                        state_nxt  = S_IDLE;
                    end else begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                end
            end
            S_LOCKOUT: begin
                if (lock_tmr == '0) begin
                    state_nxt    = S_IDLE;
                    fail_cnt_nxt = '0;
                end else begin
                    lock_tmr_nxt = lock_tmr - TMR_W'(1);
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Display/status decode of the current state; CHECK keeps the last glyphs.
    always_comb begin
        fail_sat = (int'(fail_cnt) >= 3) ? 2'd3 : 2'(fail_cnt);
        led_nxt  = {fail_sat, 4'b0000};
        ssd_nxt  = ssd;
        case (state)
            S_IDLE:    ssd_nxt = message(G_C, G_L, G_5, G_D);
            S_ENTRY: begin
                led_nxt[1] = 1'b1;
                ssd_nxt    = digit_view(idx, switch);
            end
            S_OPEN: begin
                led_nxt[0] = 1'b1;
                ssd_nxt    = message(G_0, G_P, G_E, G_N);
            end
            S_SET: begin
                led_nxt[2] = 1'b1;
                ssd_nxt    = digit_view(idx, switch);
            end
            S_LOCKOUT: begin
                led_nxt[3] = 1'b1;
                ssd_nxt    = message(G_L, G_0, G_C, G_BLANK);
            end
            default: ssd_nxt = ssd;
        endcase
    end

    // Registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            led <= '0;
            ssd <= {DIGITS{G_BLANK}};
        end else begin
            led <= led_nxt;
            ssd <= ssd_nxt;
        end
    end

endmodule

// File: tb/tb_digilock_ctrl.sv
// Testbench for digilock_ctrl (DIGITS=4, DIGIT_W=4, MAX_TRIES=3,
// LOCKOUT_CYC=16, DEFAULT_PWD=0). Drivers push expected {led, ssd} words into
// a queue; a monitor pops and compares them at the next falling edge (or at
// once on chk_now for the asynchronous reset check).
module tb_digilock_ctrl;

    localparam int W = 6 + 20;

    localparam logic [4:0] B  = 5'h10;
    localparam logic [5:0] LED_ENTRY = 6'h02;
    localparam logic [5:0] LED_SET   = 6'h04;
    localparam logic [5:0] LED_OPEN  = 6'h01;

    logic        clk;
    logic        rst_n;
    logic        clr;
    logic        enter;
    logic        change;
    logic [3:0]  switch;
    logic [5:0]  led;
    logic [19:0] ssd;

    logic [W-1:0] exp_q[$];
    string        name_q[$];
    int           checks;
    int           failures;
    event         chk_now;

    logic [19:0] idle_ssd;
    logic [19:0] open_ssd;
    logic [19:0] lock_ssd;
    logic [19:0] blank_ssd;

    digilock_ctrl #(
        .DIGITS(4),
        .DIGIT_W(4),
        .MAX_TRIES(3),
        .LOCKOUT_CYC(16),
        .DEFAULT_PWD(16'h0000)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .clr(clr),
        .enter(enter),
        .change(change),
        .switch(switch),
        .led(led),
        .ssd(ssd)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Watchdog
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, want finish before 100000");
        $fatal(1, "watchdog expired");
    end

    // Monitor / scoreboard
    initial begin
        logic [W-1:0] exp_v;
        logic [W-1:0] act_v;
        string        nm;
        forever begin
            @(negedge clk or chk_now);
            while (exp_q.size() > 0) begin
                exp_v = exp_q.pop_front();
                nm    = name_q.pop_front();
                act_v = {led, ssd};
                checks++;
                if (act_v !== exp_v) begin
                    failures++;
                    $display("FAIL %s: got led=%b ssd=%h, want led=%b ssd=%h",
                             nm, act_v[25:20], act_v[19:0], exp_v[25:20], exp_v[19:0]);
                end
            end
        end
    end

    function automatic logic [19:0] g4(input logic [4:0] a, input logic [4:0] b,
                                       input logic [4:0] c, input logic [4:0] d);
        return {a, b, c, d};
    endfunction

    task automatic expect_out(input logic [5:0] l, input logic [19:0] s, input string nm);
        exp_q.push_back({l, s});
        name_q.push_back(nm);
    endtask

    // One clock with the given pulses; returns 1 time unit after the edge.
    task automatic step(input logic en, input logic cl, input logic ch, input logic [3:0] sw);
        enter  = en;
        clr    = cl;
        change = ch;
        switch = sw;
        @(posedge clk);
        #1;
        enter  = 1'b0;
        clr    = 1'b0;
        change = 1'b0;
    endtask

    // From IDLE: start entry and key in four digits, most significant first.
    task automatic enter_code(input logic [15:0] code);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, code[15-4*i -: 4]);
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        idle_ssd  = g4(5'h0C, 5'h11, 5'h05, 5'h0D);
        open_ssd  = g4(5'h00, 5'h13, 5'h0E, 5'h14);
        lock_ssd  = g4(5'h11, 5'h00, 5'h0C, B);
        blank_ssd = g4(B, B, B, B);
        rst_n  = 1'b0;
        clr    = 1'b0;
        enter  = 1'b0;
        change = 1'b0;
        switch = 4'h0;

        // Reset values
        @(posedge clk);
        #1;
        expect_out(6'h00, blank_ssd, "reset");
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h00, idle_ssd, "idle_msg");

        // Correct default code
        step(1'b1, 1'b0, 1'b0, 4'h0);
        expect_out(6'h00, idle_ssd, "idle_before_entry");
        step(1'b1, 1'b0, 1'b0, 4'h0);
        expect_out(LED_ENTRY, g4(5'h00, B, B, B), "entry_pos0");
        step(1'b1, 1'b0, 1'b0, 4'h0);
        expect_out(LED_ENTRY, g4(B, 5'h00, B, B), "entry_pos1");
        step(1'b1, 1'b0, 1'b0, 4'h0);
        expect_out(LED_ENTRY, g4(B, B, 5'h00, B), "entry_pos2");
        step(1'b1, 1'b0, 1'b0, 4'h0);
        expect_out(LED_ENTRY, g4(B, B, B, 5'h00), "entry_pos3");
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h00, g4(B, B, B, 5'h00), "check_holds_ssd");
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(LED_OPEN, open_ssd, "open_default");

        // Change password to 1234
        step(1'b0, 1'b0, 1'b1, 4'h0);
        expect_out(LED_OPEN, open_ssd, "open_before_set");
        step(1'b1, 1'b0, 1'b0, 4'h1);
        expect_out(LED_SET, g4(5'h01, B, B, B), "set_pos0");
        step(1'b1, 1'b0, 1'b0, 4'h2);
        expect_out(LED_SET, g4(B, 5'h02, B, B), "set_pos1");
        step(1'b1, 1'b0, 1'b0, 4'h3);
        expect_out(LED_SET, g4(B, B, 5'h03, B), "set_pos2");
        step(1'b1, 1'b0, 1'b0, 4'h4);
        expect_out(LED_SET, g4(B, B, B, 5'h04), "set_pos3");
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h00, idle_ssd, "idle_after_set");

        // Old code 0000 now fails
        enter_code(16'h0000);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h00, g4(B, B, B, 5'h00), "check_old_code");
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h10, idle_ssd, "fail_cnt_1");

        // New code 1234 opens and clears the failure count
        enter_code(16'h1234);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h10, g4(B, B, B, 5'h04), "check_new_code");
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(LED_OPEN, open_ssd, "open_new_code");

        // Relock, then three wrong codes
        step(1'b1, 1'b0, 1'b0, 4'h0);
        expect_out(LED_OPEN, open_ssd, "open_before_relock");
        enter_code(16'h9999);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h10, idle_ssd, "lock_fail_1");
        enter_code(16'h9999);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h20, idle_ssd, "lock_fail_2");
        enter_code(16'h9999);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h20, g4(B, B, B, 5'h09), "check_fail_3");
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h38, lock_ssd, "lockout_first");
        for (int i = 0; i < 15; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'h9);
            expect_out(6'h38, lock_ssd, "lockout_dwell");
        end
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h00, idle_ssd, "lockout_exit");

        // clr beats enter in ENTRY
        step(1'b1, 1'b0, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h5);
        step(1'b1, 1'b0, 1'b0, 4'h6);
        step(1'b1, 1'b1, 1'b0, 4'h7);
        expect_out(LED_ENTRY, g4(B, B, 5'h07, B), "clr_entry_pos2");
        step(1'b0, 1'b0, 1'b0, 4'hA);
        expect_out(LED_ENTRY, g4(5'h0A, B, B, B), "clr_idx_zero");
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0, 4'(i + 1));
        end
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(LED_OPEN, open_ssd, "open_after_clr");

        // Set abort keeps the old password
        step(1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h9);
        step(1'b1, 1'b0, 1'b0, 4'h9);
        step(1'b1, 1'b0, 1'b0, 4'h9);
        step(1'b1, 1'b1, 1'b0, 4'h9);
        expect_out(LED_SET, g4(B, B, B, 5'h09), "set_pos3_abort");
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(LED_OPEN, open_ssd, "open_after_abort");
        step(1'b1, 1'b0, 1'b1, 4'h0);
        expect_out(LED_OPEN, open_ssd, "open_change_enter");
        step(1'b0, 1'b0, 1'b0, 4'hB);
        expect_out(LED_SET, g4(5'h0B, B, B, B), "change_beats_enter");
        step(1'b0, 1'b1, 1'b0, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h0);
        enter_code(16'h1234);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(LED_OPEN, open_ssd, "passwd_kept");

        // Asynchronous reset in the middle of SET
        step(1'b0, 1'b0, 1'b1, 4'h0);
        step(1'b1, 1'b0, 1'b0, 4'h5);
        step(1'b1, 1'b0, 1'b0, 4'h6);
        rst_n = 1'b0;
        #1;
        expect_out(6'h00, blank_ssd, "async_reset");
        -> chk_now;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(6'h00, idle_ssd, "idle_after_reset");
        enter_code(16'h0000);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        step(1'b0, 1'b0, 1'b0, 4'h0);
        expect_out(LED_OPEN, open_ssd, "default_pwd_restored");

        // Drain and report
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
